m68k_mem_arbiter: RTL

//  Shares one 16-bit memory port (BRAM or SDRAM controller) between the fx68k CPU bus and the ESP32 SPI

---
 rtl/m68k_mem_arbiter_pkg.sv | 29 ++
 rtl/m68k_mem_arbiter_spi_req_slot.sv | 71 +++++++
 rtl/m68k_mem_arbiter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/m68k_mem_arbiter_pkg.sv
// Shared types and helpers for the 68k / SPI-loader memory arbiter.
// Holds the FSM state encoding, byte-enable constants and the big-endian SPI lane map.
package m68k_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CPU_ACC = 2'd1,
        CPU_END = 2'd2,
        SPI_ACC = 2'd3
    } arb_state_e;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;
    localparam logic [1:0] BE_BOTH = 2'b11;

    localparam logic GRANT_CPU = 1'b0;
    localparam logic GRANT_SPI = 1'b1;

    // 68k is big-endian: even byte addresses live on the upper lane.
    function automatic logic [1:0] spi_lane_be(input logic a0);
        return a0 ? BE_LO : BE_HI;
    endfunction

    function automatic logic [7:0] spi_lane_byte(input logic a0, input logic [15:0] word);
        return a0 ? word[7:0] : word[15:8];
    endfunction

endpackage

// File: rtl/m68k_mem_arbiter_spi_req_slot.sv
// One-entry holding register for SPI loader byte accesses.
// Filters on the page byte, keeps the request until the arbiter clears it, and flags dropped strobes.
module spi_req_slot
    import m68k_bus_pkg::*;
#(
    parameter int         C_ADDR_BITS = 23,
    parameter logic [7:0] C_SPI_PAGE  = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   spi_wr_i,
    input  logic                   spi_rd_i,
    input  logic [31:0]            spi_addr_i,
    input  logic [7:0]             spi_wdata_i,
    input  logic                   clr_i,
    output logic                   vld_o,
    output logic                   we_o,
    output logic                   lane_o,
    output logic [1:0]             be_o,
    output logic [C_ADDR_BITS-1:0] addr_o,
    output logic [15:0]            wdata_o,
    output logic                   ovf_o
);

    logic                   vld_q;
    logic                   ovf_q;
    logic                   we_q;
    logic                   lane_q;
    logic [C_ADDR_BITS-1:0] addr_q;
    logic [7:0]             byte_q;
    logic                   hit;

    assign hit = (spi_wr_i | spi_rd_i) && (spi_addr_i[31:24] == C_SPI_PAGE);

    // A strobe landing while the slot is still occupied is lost, even on the clearing edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            if (clr_i) begin
                vld_q <= 1'b0;
            end
            if (hit) begin
                if (vld_q) begin
                    ovf_q <= 1'b1;
                end else begin
                    vld_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hit && !vld_q) begin
            we_q   <= spi_wr_i;
            lane_q <= spi_addr_i[0];
            addr_q <= spi_addr_i[C_ADDR_BITS:1];
            byte_q <= spi_wdata_i;
        end
    end

    assign vld_o   = vld_q;
    assign ovf_o   = ovf_q;
    assign we_o    = we_q;
    assign lane_o  = lane_q;
    assign be_o    = spi_lane_be(lane_q);
    assign addr_o  = addr_q;
    assign wdata_o = {byte_q, byte_q};

endmodule

// File: rtl/m68k_mem_arbiter.sv
// Shares one 16-bit memory port between the fx68k bus and the SPI loader.
// Generates DTACKn/BERRn for the CPU and round-robins when both sides are waiting.
module m68k_mem_arbiter
    import m68k_bus_pkg::*;
#(
    parameter int         C_ADDR_BITS = 23,
    parameter int         C_TIMEOUT   = 255,
    parameter logic [7:0] C_SPI_PAGE  = 8'h00
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cpu_as_n,
    input  logic                   cpu_uds_n,
    input  logic                   cpu_lds_n,
    input  logic                   cpu_rw,
    input  logic [C_ADDR_BITS-1:0] cpu_a,
    input  logic [15:0]            cpu_dout,
    output logic [15:0]            cpu_din,
    output logic                   cpu_dtack_n,
    output logic                   cpu_berr_n,
    input  logic                   spi_wr,
    input  logic                   spi_rd,
    input  logic [31:0]            spi_addr,
    input  logic [7:0]             spi_wdata,
    output logic [7:0]             spi_rdata,
    output logic                   spi_rvalid,
    output logic                   spi_ovf,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [1:0]             mem_be,
    output logic [C_ADDR_BITS-1:0] mem_addr,
    output logic [15:0]            mem_wdata,
    input  logic [15:0]            mem_rdata,
    input  logic                   mem_ack
);

    localparam logic [7:0] TMO_LAST = 8'(C_TIMEOUT - 1);

    arb_state_e             state_q;
    logic                   last_grant_q;
    logic [7:0]             tmo_q;
    logic [15:0]            cpu_din_q;
    logic                   dtack_n_q;
    logic                   berr_n_q;
    logic [7:0]             spi_rdata_q;
    logic                   spi_rvalid_q;
    logic                   mem_req_q;
    logic                   mem_we_q;
    logic [1:0]             mem_be_q;
    logic [C_ADDR_BITS-1:0] mem_addr_q;
    logic [15:0]            mem_wdata_q;

    logic                   slot_vld;
    logic                   slot_we;
    logic                   slot_lane;
    logic [1:0]             slot_be;
    logic [C_ADDR_BITS-1:0] slot_addr;
    logic [15:0]            slot_wdata;
    logic                   slot_clr;

    logic                   cpu_pend;
    logic                   pick_cpu;
    logic                   tmo_fire;

    assign cpu_pend = ~cpu_as_n & (~cpu_uds_n | ~cpu_lds_n);
    // Contention goes to whoever did not win last time.
    assign pick_cpu = cpu_pend & (~slot_vld | (last_grant_q == GRANT_SPI));
    assign tmo_fire = (tmo_q == TMO_LAST);
    assign slot_clr = (state_q == SPI_ACC) & (mem_ack | tmo_fire);

    spi_req_slot #(
        .C_ADDR_BITS (C_ADDR_BITS),
        .C_SPI_PAGE  (C_SPI_PAGE)
    ) u_slot (
        .clk         (clk),
        .reset_n     (reset_n),
        .spi_wr_i    (spi_wr),
        .spi_rd_i    (spi_rd),
        .spi_addr_i  (spi_addr),
        .spi_wdata_i (spi_wdata),
        .clr_i       (slot_clr),
        .vld_o       (slot_vld),
        .we_o        (slot_we),
        .lane_o      (slot_lane),
        .be_o        (slot_be),
        .addr_o      (slot_addr),
        .wdata_o     (slot_wdata),
        .ovf_o       (spi_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_SPI;
            tmo_q        <= 8'd0;
            cpu_din_q    <= 16'd0;
            dtack_n_q    <= 1'b1;
            berr_n_q     <= 1'b1;
            spi_rdata_q  <= 8'd0;
            spi_rvalid_q <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= BE_NONE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 16'd0;
        end else begin
            spi_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_cpu) begin
                        state_q      <= CPU_ACC;
                        last_grant_q <= GRANT_CPU;
                        tmo_q        <= 8'd0;
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= ~cpu_rw;
                        mem_be_q     <= {~cpu_uds_n, ~cpu_lds_n};
                        mem_addr_q   <= cpu_a;
                        mem_wdata_q  <= cpu_dout;
                    end else if (slot_vld) begin
                        state_q      <= SPI_ACC;
                        last_grant_q <= GRANT_SPI;
                        tmo_q        <= 8'd0;
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= slot_we;
                        mem_be_q     <= slot_be;
                        mem_addr_q   <= slot_addr;
                        mem_wdata_q  <= slot_wdata;
                    end
                end
                CPU_ACC: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        dtack_n_q <= 1'b0;
                        if (!mem_we_q) begin
                            cpu_din_q <= mem_rdata;
                        end
                        state_q <= CPU_END;
                    end else if (tmo_fire) begin
                        mem_req_q <= 1'b0;
                        berr_n_q  <= 1'b0;
                        state_q   <= CPU_END;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                // Hold the acknowledge until the CPU ends its bus cycle.
                CPU_END: begin
                    if (cpu_as_n) begin
                        dtack_n_q <= 1'b1;
                        berr_n_q  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                SPI_ACC: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        if (!mem_we_q) begin
                            spi_rdata_q  <= spi_lane_byte(slot_lane, mem_rdata);
                            spi_rvalid_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end else if (tmo_fire) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_din     = cpu_din_q;
    assign cpu_dtack_n = dtack_n_q;
    assign cpu_berr_n  = berr_n_q;
    assign spi_rdata   = spi_rdata_q;
    assign spi_rvalid  = spi_rvalid_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_be      = mem_be_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule
